alu_led_scanner: RTL and testbench

Registered LED display sequencer for the ALU result bus of the lab datapath. It presents one byte lane of a parametrised result word, or a flag page, on an 8-bit LED bank. Lane selection is either manual from switches or automatic, stepping through all pages at a programmable dwell rate. It sits between the ALU outputs and the board LED pins and replaces purely combinational byte muxing.

---
 rtl/alu_led_scanner.sv | 192 +++++++++++++++++++
 tb/tb_alu_led_scanner.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_led_scanner.sv
// ---------------------------------------------------------------------------
// alu_led_scanner
//
// Registered LED display sequencer for the ALU result bus. Shows one byte
// lane of the result word, or a flag page, on an 8-bit LED bank. The page is
// picked manually from switches or stepped automatically, with each page
// held for DWELL clock cycles.
//
// Optional feature macro: LED_HOLD_EN
//   defined   : F and flags are sampled into hold registers when capture=1,
//               and LED shows the held copy.
//   undefined : LED shows the live F and flags; capture is ignored.
//
// Parameters:
//   DATA_W  result width, multiple of 8, 8..64
//   SEL_W   select/lane width, 2**SEL_W > DATA_W/8
//   DWELL   cycles per page in scan mode, >= 1
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   F           ALU result
//   ZF/CF/SF/OF ALU flags
//   capture     load hold registers (LED_HOLD_EN only)
//   auto        1 = automatic page scan, 0 = manual select
//   F_LED_SW    manual page select
//   LED         displayed page, registered
//   lane        page index currently driving LED, registered
//   o_dbg_mode  current mode (0 = MANUAL, 1 = SCAN), registered
//
// Handshake: none. Every input is sampled on every rising edge and the
// outputs reflect that sample one cycle later.
// ---------------------------------------------------------------------------
module alu_led_scanner #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 3,
    parameter int DWELL  = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] F,
    input  logic              ZF,
    input  logic              CF,
    input  logic              SF,
    input  logic              OF,
    input  logic              capture,
    input  logic              auto,
    input  logic [SEL_W-1:0]  F_LED_SW,
    output logic [7:0]        LED,
    output logic [SEL_W-1:0]  lane,
    output logic              o_dbg_mode
);

    localparam int NLANE = DATA_W / 8;
    localparam int CNT_W = $clog2(DWELL + 1);
    localparam logic [SEL_W-1:0] FLAG_PAGE = SEL_W'(NLANE);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } mode_t;

    mode_t             r_mode;
    logic [CNT_W-1:0]  r_cnt;
    logic [SEL_W-1:0]  r_lane;
    logic [7:0]        r_led;

    logic [DATA_W-1:0] w_src_f;
    logic              w_src_zf;
    logic              w_src_cf;
    logic              w_src_sf;
    logic              w_src_of;

`ifdef LED_HOLD_EN
    logic [DATA_W-1:0] r_hold_f;
    logic              r_hold_zf;
    logic              r_hold_cf;
    logic              r_hold_sf;
    logic              r_hold_of;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_f  <= '0;
            r_hold_zf <= 1'b0;
            r_hold_cf <= 1'b0;
            r_hold_sf <= 1'b0;
            r_hold_of <= 1'b0;
        end else if (capture) begin
            r_hold_f  <= F;
            r_hold_zf <= ZF;
            r_hold_cf <= CF;
            r_hold_sf <= SF;
            r_hold_of <= OF;
        end
    end

    assign w_src_f  = r_hold_f;
    assign w_src_zf = r_hold_zf;
    assign w_src_cf = r_hold_cf;
    assign w_src_sf = r_hold_sf;
    assign w_src_of = r_hold_of;
`else
    // capture has no function without hold registers.
    logic w_unused_capture;
    assign w_unused_capture = capture;

    assign w_src_f  = F;
    assign w_src_zf = ZF;
    assign w_src_cf = CF;
    assign w_src_sf = SF;
    assign w_src_of = OF;
`endif

    // Any switch value past the last byte lane selects the flag page.
    logic [SEL_W-1:0] w_sw_page;
    assign w_sw_page = (F_LED_SW >= FLAG_PAGE) ? FLAG_PAGE : F_LED_SW;

    // Scan order is lanes 0..NLANE-1, then the flag page, then wrap.
    logic [SEL_W-1:0] w_scan_next;
    assign w_scan_next = (r_lane >= FLAG_PAGE) ? '0 : r_lane + SEL_W'(1);

    mode_t            w_next_mode;
    logic [CNT_W-1:0] w_next_cnt;
    logic [SEL_W-1:0] w_next_lane;

    // A mode change takes priority over the dwell terminal count.
    always_comb begin
        w_next_mode = r_mode;
        w_next_cnt  = r_cnt;
        w_next_lane = r_lane;
        case (r_mode)
            MANUAL: begin
                if (auto) begin
                    w_next_mode = SCAN;
                    w_next_cnt  = '0;
                    w_next_lane = '0;
                end else begin
                    w_next_lane = w_sw_page;
                end
            end
            SCAN: begin
                if (!auto) begin
                    w_next_mode = MANUAL;
                    w_next_cnt  = '0;
                    w_next_lane = w_sw_page;
                end else if (r_cnt == CNT_LAST) begin
                    w_next_cnt  = '0;
                    w_next_lane = w_scan_next;
                end else begin
                    w_next_cnt  = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_next_mode = MANUAL;
                w_next_cnt  = '0;
                w_next_lane = '0;
            end
        endcase
    end

    // LED is computed from the lane that will be current after this edge,
    // so the display and the lane index always move together.
    logic [7:0] w_page_led;
    always_comb begin
        w_page_led = {w_src_zf, w_src_cf, w_src_sf, 4'b0000, w_src_of};
        for (int k = 0; k < NLANE; k++) begin
            if (w_next_lane == SEL_W'(k)) begin
                w_page_led = w_src_f[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MANUAL;
            r_cnt  <= '0;
            r_lane <= '0;
            r_led  <= 8'h00;
        end else begin
            r_mode <= w_next_mode;
            r_cnt  <= w_next_cnt;
            r_lane <= w_next_lane;
            r_led  <= w_page_led;
        end
    end

    assign LED        = r_led;
    assign lane       = r_lane;
    assign o_dbg_mode = (r_mode == SCAN);

endmodule

// File: tb/tb_alu_led_scanner.sv
// ---------------------------------------------------------------------------
// tb_alu_led_scanner
//
// Two instances share one stimulus stream:
//   u_a : DATA_W=32, SEL_W=3, DWELL=3
//   u_b : DATA_W=64, SEL_W=4, DWELL=1
// A reference model derives the expected page from elapsed scan time and
// switch position; a compare process checks every falling edge. Directed
// literal checks pin the model on hand-worked cases.
// ---------------------------------------------------------------------------
module tb_alu_led_scanner;

`ifdef LED_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [63:0] f;
    logic        zf, cf, sf, of;
    logic        capture;
    logic        auto;
    logic [3:0]  sw;

    logic [7:0]  led_a;
    logic [2:0]  lane_a;
    logic        mode_a;
    logic [7:0]  led_b;
    logic [3:0]  lane_b;
    logic        mode_b;

    alu_led_scanner #(.DATA_W(32), .SEL_W(3), .DWELL(3)) u_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .F          (f[31:0]),
        .ZF         (zf),
        .CF         (cf),
        .SF         (sf),
        .OF         (of),
        .capture    (capture),
        .auto       (auto),
        .F_LED_SW   (sw[2:0]),
        .LED        (led_a),
        .lane       (lane_a),
        .o_dbg_mode (mode_a)
    );

    alu_led_scanner #(.DATA_W(64), .SEL_W(4), .DWELL(1)) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .F          (f),
        .ZF         (zf),
        .CF         (cf),
        .SF         (sf),
        .OF         (of),
        .capture    (capture),
        .auto       (auto),
        .F_LED_SW   (sw),
        .LED        (led_b),
        .lane       (lane_b),
        .o_dbg_mode (mode_b)
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int NL[2] = '{4, 8};
    int DW[2] = '{3, 1};

    int          m_scan[2];
    int          m_t[2];
    int          exp_led[2];
    int          exp_lane[2];
    logic [63:0] m_hf;
    logic [3:0]  m_hfl;

    // fl = {ZF, CF, SF, OF}
    function automatic int page_led(input logic [63:0] src, input logic [3:0] fl,
                                    input int page, input int nl);
        logic [7:0] v;
        if (page >= nl) v = {fl[3], fl[2], fl[1], 4'b0000, fl[0]};
        else            v = 8'(src >> (8 * page));
        return int'(v);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [63:0] src;
        logic [3:0]  sfl;
        int          pg;
        int          swv;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_scan[i]   = 0;
                m_t[i]      = 0;
                exp_led[i]  = 0;
                exp_lane[i] = 0;
            end
            m_hf  = '0;
            m_hfl = '0;
        end else begin
            src = HOLD_EN ? m_hf  : f;
            sfl = HOLD_EN ? m_hfl : {zf, cf, sf, of};
            for (int i = 0; i < 2; i++) begin
                swv = (i == 0) ? int'(sw[2:0]) : int'(sw);
                if (auto) begin
                    if (m_scan[i] == 0) begin
                        m_scan[i] = 1;
                        m_t[i]    = 0;
                    end else begin
                        m_t[i]++;
                    end
                    // Elapsed scan time decides the page directly.
                    pg = (m_t[i] / DW[i]) % (NL[i] + 1);
                end else begin
                    m_scan[i] = 0;
                    pg = (swv >= NL[i]) ? NL[i] : swv;
                end
                exp_lane[i] = pg;
                exp_led[i]  = page_led(src, sfl, pg, NL[i]);
            end
            if (capture) begin
                m_hf  = f;
                m_hfl = {zf, cf, sf, of};
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("model_led_a",  int'(led_a),  exp_led[0]);
            check("model_lane_a", int'(lane_a), exp_lane[0]);
            check("model_mode_a", int'(mode_a), m_scan[0]);
            check("model_led_b",  int'(led_b),  exp_led[1]);
            check("model_lane_b", int'(lane_b), exp_lane[1]);
            check("model_mode_b", int'(mode_b), m_scan[1]);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [63:0] val, input logic [3:0] fl);
        f = val;
        {zf, cf, sf, of} = fl;
        capture = 1'b1;
        step(1);
        capture = 1'b0;
        step(1);
    endtask

    logic [7:0] man_exp[4]  = '{8'hEF, 8'hCD, 8'hAB, 8'h89};
    logic [7:0] scan_exp[5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h40};

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        f = '0;
        {zf, cf, sf, of} = 4'b0000;
        capture = 1'b0;
        auto = 1'b0;
        sw = 4'd0;
        step(2);
        rst_n = 1'b1;
        chk_on = 1'b1;
        step(1);
        check("reset_led_a",  int'(led_a),  0);
        check("reset_lane_a", int'(lane_a), 0);

        // Manual byte select
        load(64'h0123_4567_89AB_CDEF, 4'b1011);
        for (int k = 0; k < 4; k++) begin
            sw = 4'(k);
            step(1);
            check($sformatf("man_led_a_%0d", k), int'(led_a), int'(man_exp[k]));
        end
        sw = 4'd7;
        step(1);
        check("flag_led_a",  int'(led_a),  8'hA1);
        check("flag_lane_a", int'(lane_a), 4);
        check("w64_led_b",   int'(led_b),  8'h01);
        check("w64_lane_b",  int'(lane_b), 7);
        sw = 4'd8;
        step(1);
        check("w64_flag_b",  int'(led_b),  8'hA1);
        check("w64_flagl_b", int'(lane_b), 8);

        // Auto scan
        load(64'h0000_0000_0403_0201, 4'b0100);
        sw = 4'd0;
        auto = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(1);
            check($sformatf("scan_led_a_%0d", i),  int'(led_a),  int'(scan_exp[(i / 3) % 5]));
            check($sformatf("scan_lane_a_%0d", i), int'(lane_a), (i / 3) % 5);
        end

        // Drop auto mid-page
        step(1);
        sw = 4'd2;
        auto = 1'b0;
        step(1);
        check("drop_led_a",  int'(led_a),  8'h03);
        check("drop_lane_a", int'(lane_a), 2);

        // Raise auto while counter of u_b is always at terminal count
        auto = 1'b1;
        step(1);
        check("rise_lane_b", int'(lane_b), 0);
        check("rise_led_b",  int'(led_b),  8'h01);
        check("rise_lane_a", int'(lane_a), 0);
        step(1);
        check("dw1_lane_b",  int'(lane_b), 1);
        check("dw1_led_b",   int'(led_b),  8'h02);

        // Hold behaviour
        auto = 1'b0;
        sw = 4'd0;
        load(64'h1111_1111_1111_1111, 4'b0000);
        check("hold_first", int'(led_a), 8'h11);
        f = 64'h2222_2222_2222_2222;
        step(2);
        check("hold_frozen", int'(led_a), HOLD_EN ? 8'h11 : 8'h22);
        capture = 1'b1;
        step(1);
        capture = 1'b0;
        check("hold_edge", int'(led_a), HOLD_EN ? 8'h11 : 8'h22);
        step(1);
        check("hold_new", int'(led_a), 8'h22);

        // Asynchronous reset mid-scan
        auto = 1'b1;
        step(2);
        #2 rst_n = 1'b0;
        #1;
        check("async_led_a",  int'(led_a),  0);
        check("async_lane_a", int'(lane_a), 0);
        check("async_led_b",  int'(led_b),  0);
        check("async_lane_b", int'(lane_b), 0);
        step(1);
        rst_n = 1'b1;
        step(2);

        // Randomized phase
        repeat (3000) begin
            if ($urandom_range(0, 19) == 0) auto = ~auto;
            sw = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) f = {$urandom, $urandom};
            {zf, cf, sf, of} = 4'($urandom_range(0, 15));
            capture = ($urandom_range(0, 3) == 0);
            step(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
